// File: rtl/stage_wb_seq.sv
// Write-back sequencer: merges MEM/WB pipeline results with buffered long-latency-unit results
// onto one registered register-file write port (1-cycle latency); LU side uses valid/ready, ready = FIFO not full.
module stage_wb_seq #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              wb_regs_write,
  input  logic              wb_mem2reg,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_mem_rdata,
  input  logic [DATA_W-1:0] wb_data2,
  input  logic              wb_have_mop,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  input  logic [DATA_W-1:0] lu_data2,
  input  logic              lu_mop,
  output logic              w_regs_en,
  output logic [ADDR_W-1:0] w_regs_addr,
  output logic [DATA_W-1:0] w_regs_data,
  output logic [DATA_W-1:0] w_regs_data2,
  output logic              w_regs_mop_en,
  output logic              lu_pending,
  output logic              wb_stall_req,
  output logic              wb_drop_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic              mop;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] data2;
  } ent_t;

  ent_t              mem_q [FIFO_DEPTH];
  ent_t              mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              drop_q, drop_d;
  logic              ready_en_q, ready_en_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [DATA_W-1:0] w_data2_q, w_data2_d;
  logic              w_mop_q, w_mop_d;

  logic pq;
  logic fifo_ne;
  logic lu_rdy;
  logic push;
  logic pop;
  logic sel_pipe;
  ent_t head;
  ent_t push_ent;

  always_comb begin
    pq       = wb_valid & wb_regs_write & (wb_rd != '0);
    fifo_ne  = (cnt_q != '0);
    // ready comes only from registered state; a pop this cycle does not free a slot early
    lu_rdy   = ready_en_q & (cnt_q < CW'(FIFO_DEPTH));
    push     = lu_valid & lu_rdy & (lu_rd != '0);
    sel_pipe = pq & ~stall_q;
    pop      = fifo_ne & (stall_q | ~pq);
    head     = mem_q[rd_ptr_q];

    push_ent.mop   = lu_mop;
    push_ent.rd    = lu_rd;
    push_ent.data  = lu_data;
    push_ent.data2 = lu_data2;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || !fifo_ne) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
    // one-cycle request; the head pops during it, which clears the counter
    stall_d    = (starve_d == SW'(STARVE_MAX)) & ~stall_q;
    drop_d     = drop_q | (pq & stall_q);
    ready_en_d = 1'b1;
  end

  always_comb begin
    w_en_d    = sel_pipe | pop;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_data2_d = w_data2_q;
    w_mop_d   = w_mop_q;
    if (sel_pipe) begin
      w_addr_d  = wb_rd;
      w_data_d  = wb_mem2reg ? wb_mem_rdata : wb_alu_result;
      w_data2_d = wb_data2;
      w_mop_d   = wb_have_mop;
    end else if (pop) begin
      w_addr_d  = head.rd;
      w_data_d  = head.data;
      w_data2_d = head.data2;
      w_mop_d   = head.mop;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      drop_q     <= 1'b0;
      ready_en_q <= 1'b0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_data2_q  <= '0;
      w_mop_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      drop_q     <= drop_d;
      ready_en_q <= ready_en_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_data2_q  <= w_data2_d;
      w_mop_q    <= w_mop_d;
    end
  end

  assign lu_ready      = lu_rdy;
  assign lu_pending    = fifo_ne;
  assign wb_stall_req  = stall_q;
  assign wb_drop_err   = drop_q;
  assign w_regs_en     = w_en_q;
  assign w_regs_addr   = w_addr_q;
  assign w_regs_data   = w_data_q;
  assign w_regs_data2  = w_data2_q;
  assign w_regs_mop_en = w_mop_q;

endmodule
